cntr_param: RTL
===============

Name: cntr_param

Overview:
- Parametrised up/down counter with a 6-state control FSM.
- Loads a value, counts up in alternating +1/+2 steps, counts down in alternating -1/-2 steps, or holds.
- Adds selectable wrap/saturate arithmetic, a boundary-crossing pulse and a sticky overflow flag.
- Used as the general-purpose counter primitive beside the shifter and register-file blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
SAT, 0, 0 = modular wrap-around, 1 = saturate at 0 / 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
en  input  1  count enable; 0 = hold (IDLE)
load  input  1  load d_in; priority over en/inc
inc  input  1  direction when en=1: 1 = up, 0 = down
clr_ovf  input  1  synchronous clear of ovf
d_in  input  WIDTH  load data
d_out  output  WIDTH  registered counter value
o_state  output  3  current FSM state
tc  output  1  one-cycle pulse: last update crossed a range boundary
ovf  output  1  sticky overflow/underflow flag

Behaviour:
- One clock; reset is asynchronous and active-high.
- reset=1 immediately forces d_out=0, o_state=IDLE(3'b000), tc=0, ovf=0, independent of clk.
- Reset may assert mid-operation; the counter resumes from IDLE on the first edge after release.
- State encoding: IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101. Codes 110/111 are unreachable; if entered, next edge goes to IDLE with d_out held.
- Next-state priority, evaluated every rising edge:
  1. load=1 -> LOAD (from any state).
  2. else en=0 -> IDLE.
  3. else inc=1: INC -> INC2; INC2 -> INC; any other state -> INC.
  4. else inc=0: DEC -> DEC2; DEC2 -> DEC; any other state -> DEC.
- d_out update on the same edge, selected by the next state (one-cycle latency from inputs to d_out):
  - LOAD: d_in.
  - IDLE: hold.
  - INC: +1. INC2: +2. DEC: -1. DEC2: -2.
- Arithmetic is computed at WIDTH+1 bits.
- Boundary event: the true result is > 2^WIDTH-1 or < 0.
  - SAT=0: result taken modulo 2^WIDTH (0xFF+2 -> 0x01 for WIDTH=8).
  - SAT=1: result clamped to 2^WIDTH-1 (up) or 0 (down).
- Landing exactly on 0 or 2^WIDTH-1 is NOT a boundary event.
- tc: registered; 1 for exactly the cycle after an edge that had a boundary event, else 0. LOAD and IDLE never raise tc.
- ovf: set on any boundary event; cleared by clr_ovf=1 at an edge. Simultaneous set and clear -> ovf=1 (set wins). Holds its value while in IDLE.
- Direction reversal (INC2 -> inc=0) enters DEC, not DEC2. Re-enabling from IDLE always starts with a single step.
- o_state, d_out, tc and ovf are all registered; there are no combinational input-to-output paths.

Test Plan:
1. WIDTH=8, SAT=0: reset, release; en=1, inc=1 for 5 edges -> o_state 010,011,010,011,010; d_out 0x01,0x03,0x04,0x06,0x07; tc=0, ovf=0 throughout.
2. SAT=0: load=1, d_in=0xFE for 1 edge (d_out=0xFE, o_state=001); then en=1, inc=1 -> 0xFF (tc=0), then 0x01 (INC2, wrap); tc=1 for one cycle; ovf=1 and stays 1 until clr_ovf.
3. SAT=1: load 0x01; en=1, inc=0 -> DEC d_out=0x00 (tc=0); DEC2 d_out=0x00 (clamped), tc=1, ovf=1. Repeat with load 0xFE, inc=1 -> 0xFF then clamp 0xFF, tc=1.
4. Priority/hold: counting at 0x10 in INC; en=0 -> IDLE, d_out stays 0x10 over 3 edges; load=1 with en=0, d_in=0x5A -> LOAD, d_out=0x5A; en=1, inc=1 -> INC, 0x5B.
5. Async reset: while counting at 0x37, assert reset 3 ns after a rising edge -> d_out=0x00, o_state=000, ovf=0 before the next edge; release; with en=1, inc=1 the first edge gives INC, 0x01.
6. ovf clear race: ovf=1, clr_ovf=1 on the same edge as a new wrap (0xFF+1) -> ovf remains 1. Next edge with clr_ovf=1 and no event -> ovf=0.

Source files
------------

// File: rtl/cntr_param.sv
// Up/down counter with load, alternating single/double steps, wrap or saturate arithmetic.
// Latency: one cycle from inputs to every output; all outputs registered.
// Backpressure: none; the counter accepts its controls on every rising edge.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   en, load, inc      hold/count enable, load request (highest priority), direction
//   clr_ovf            synchronous clear of the sticky overflow flag (a same-edge set wins)
//   d_in               load value
//   d_out, o_state     registered counter value and FSM state code
//   tc, ovf            one-cycle boundary pulse, sticky overflow/underflow flag
module cntr_param #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             evt;
    logic [WIDTH:0]   step_w;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Next-state selection. The single/double alternation only continues while
    // staying in the same direction; any other entry point restarts with a single step.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, LOAD, INC, INC2, DEC, DEC2: begin
                if (load)
                    state_nxt = LOAD;
                else if (!en)
                    state_nxt = IDLE;
                else if (inc)
                    state_nxt = (state == INC) ? INC2 : INC;
                else
                    state_nxt = (state == DEC) ? DEC2 : DEC;
            end
            // Codes 110/111 should never occur; fall back to IDLE with the value held.
            default: state_nxt = IDLE;
        endcase
    end

    // One extra bit of headroom: for the sum it is the carry out, for the
    // difference it is the borrow; either one marks a range-boundary crossing.
    always_comb begin
        step_w    = '0;
        step_w[1] = (state_nxt == INC2) || (state_nxt == DEC2);
        step_w[0] = !step_w[1];
        sum       = {1'b0, d_out} + step_w;
        diff      = {1'b0, d_out} - step_w;
    end

    always_comb begin
        d_nxt = d_out;
        evt   = 1'b0;
        case (state_nxt)
            LOAD: d_nxt = d_in;
            INC, INC2: begin
                evt   = sum[WIDTH];
                d_nxt = (SAT && evt) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
            end
            DEC, DEC2: begin
                evt   = diff[WIDTH];
                d_nxt = (SAT && evt) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
            end
            default: d_nxt = d_out;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            d_out <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            d_out <= d_nxt;
            tc    <= evt;
            ovf   <= evt | (ovf & ~clr_ovf);
        end
    end

    assign o_state = state;

endmodule
